regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 87 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter (ALU vs load unit) in front of a single register-file
// write port, with a pending-write scoreboard and a saturating contention counter.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic [4:0]  wr_addr,
  output logic [31:0] data_in,
  output logic        write_enable,
  output logic [31:0] busy_mask,
  output logic [7:0]  stall_count
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_beat_t;

  // ptr_q=1 favours the load unit (B), ptr_q=0 favours the ALU (A)
  logic        ptr_q, ptr_d;
  logic        we_q, we_d;
  wb_beat_t    beat_q, beat_d;
  logic [31:0] busy_q, busy_d;
  logic [7:0]  stall_q, stall_d;
  logic [31:0] set_mask, clr_mask;

  always_comb begin
    a_ready = ~rst & a_valid & (~b_valid | ~ptr_q);
    b_ready = ~rst & b_valid & (~a_valid | ptr_q);
  end

  always_comb begin
    ptr_d  = ptr_q;
    beat_d = beat_q;
    we_d   = 1'b0;
    if (a_ready) begin
      ptr_d  = 1'b1;
      beat_d = '{addr: a_addr, data: a_data};
      we_d   = (a_addr != 5'd0);
    end else if (b_ready) begin
      ptr_d  = 1'b0;
      beat_d = '{addr: b_addr, data: b_data};
      we_d   = (b_addr != 5'd0);
    end
  end

  // Clear retires on the same edge the register file captures the write; set wins.
  always_comb begin
    clr_mask = we_q ? (32'd1 << beat_q.addr) : 32'd0;
    set_mask = (issue_valid && issue_addr != 5'd0) ? (32'd1 << issue_addr) : 32'd0;
    busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    stall_d  = stall_q;
    if (a_valid && b_valid && stall_q != 8'hFF) stall_d = stall_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= 1'b1;
      we_q    <= 1'b0;
      beat_q  <= '0;
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign write_enable = we_q;
  assign wr_addr      = beat_q.addr;
  assign data_in      = beat_q.data;
  assign busy_mask    = busy_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: vector table with ready expectations, write scoreboard queue,
// plus hand-written async-reset and saturation sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_addr, b_addr, issue_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [4:0]  wr_addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] busy_mask;
  logic [7:0]  stall_count;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .wr_addr(wr_addr), .data_in(data_in), .write_enable(write_enable),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [4:0] aa; logic [31:0] ad;
    logic        bv;  logic [4:0] ba; logic [31:0] bd;
    logic        iv;  logic [4:0] ia;
    logic        ear; logic       ebr;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] busy_m;
  logic [7:0]  stall_m;
  logic        last_we;
  logic [4:0]  last_addr;
  vec_t        vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic iv, input logic [4:0] ia,
                              input logic ear, input logic ebr);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.iv = iv; v.ia = ia; v.ear = ear; v.ebr = ebr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
    issue_valid = v.iv; issue_addr = v.ia;
  endtask

  // One cycle: drive at negedge, check readys, predict, check registered outputs after edge.
  task automatic step(input string tag, input vec_t v);
    wr_t e;
    logic [31:0] clr, set;
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " a_ready"}, 32'(a_ready), 32'(v.ear));
    chk({tag, " b_ready"}, 32'(b_ready), 32'(v.ebr));
    if (v.ear)      sb.push_back('{we: v.aa != 0, addr: v.aa, data: v.ad});
    else if (v.ebr) sb.push_back('{we: v.ba != 0, addr: v.ba, data: v.bd});
    else            sb.push_back('{we: 1'b0, addr: 5'd0, data: 32'd0});
    clr = last_we ? (32'd1 << last_addr) : 32'd0;
    set = (v.iv && v.ia != 0) ? (32'd1 << v.ia) : 32'd0;
    busy_m = (busy_m & ~clr) | set;
    if (v.av && v.bv && stall_m != 8'd255) stall_m = stall_m + 8'd1;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " write_enable"}, 32'(write_enable), 32'(e.we));
    if (e.we) begin
      chk({tag, " wr_addr"}, 32'(wr_addr), 32'(e.addr));
      chk({tag, " data_in"}, data_in, e.data);
    end
    chk({tag, " busy_mask"}, busy_mask, busy_m);
    chk({tag, " stall_count"}, 32'(stall_count), 32'(stall_m));
    last_we = e.we; last_addr = e.addr;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0, 0,0,0, 0,0, 0,0);
    //            av aa   ad            bv ba bd            iv ia  ear ebr
    vecs[0]  = mk(1, 5, 32'h12345678,  0, 0, 0,            0, 0,  1, 0);
    vecs[1]  = idle;
    vecs[2]  = mk(1, 1, 32'h0000AAA1,  1, 2, 32'h0000BBB2, 0, 0,  0, 1);
    vecs[3]  = mk(1, 1, 32'h0000AAA1,  1, 2, 32'h0000BBB2, 0, 0,  1, 0);
    vecs[4]  = mk(1, 1, 32'h0000AAA1,  1, 2, 32'h0000BBB2, 0, 0,  0, 1);
    vecs[5]  = mk(0, 0, 0,             1, 0, 32'hFFFFFFFF, 0, 0,  0, 1);
    vecs[6]  = mk(0, 0, 0,             0, 0, 0,            1, 7,  0, 0);
    vecs[7]  = idle;
    vecs[8]  = mk(1, 7, 32'hAAAA5555,  0, 0, 0,            0, 0,  1, 0);
    vecs[9]  = idle;
    vecs[10] = mk(0, 0, 0,             0, 0, 0,            1, 7,  0, 0);
    vecs[11] = mk(1, 7, 32'h00000001,  0, 0, 0,            0, 0,  1, 0);
    vecs[12] = mk(0, 0, 0,             0, 0, 0,            1, 7,  0, 0);
    vecs[13] = mk(0, 0, 0,             1, 3, 32'h00000033, 1, 0,  0, 1);

    busy_m = '0; stall_m = '0; last_we = 1'b0; last_addr = '0;

    // Reset holds everything at zero and blocks handshakes even across an edge.
    rst = 1'b1;
    drive(mk(1, 4, 32'h44, 1, 6, 32'h66, 1, 9, 0, 0));
    #7;
    chk("rst a_ready", 32'(a_ready), 0);
    chk("rst b_ready", 32'(b_ready), 0);
    chk("rst write_enable", 32'(write_enable), 0);
    chk("rst busy_mask", busy_mask, 0);
    chk("rst stall_count", 32'(stall_count), 0);
    chk("rst wr_addr", 32'(wr_addr), 0);
    @(negedge clk);
    drive(idle);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) step($sformatf("vec%0d", i), vecs[i]);
    chk("contention stall_count", 32'(stall_count), 3);

    // Async reset between edges while a write is on the port and busy is non-zero.
    step("pre_rst", mk(1, 9, 32'hDEADBEEF, 0, 0, 0, 1, 9, 1, 0));
    #2;
    drive(mk(1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    chk("async write_enable", 32'(write_enable), 0);
    chk("async wr_addr", 32'(wr_addr), 0);
    chk("async data_in", data_in, 0);
    chk("async busy_mask", busy_mask, 0);
    chk("async stall_count", 32'(stall_count), 0);
    chk("async a_ready", 32'(a_ready), 0);
    @(negedge clk);
    drive(idle);
    rst = 1'b0;
    sb.delete();
    busy_m = '0; stall_m = '0; last_we = 1'b0; last_addr = '0;
    step("post_rst idle", idle);
    step("post_rst ptrB", mk(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 1));
    step("post_rst flush", idle);

    // Saturation: stall_count starts at 1 here and must stop at 255.
    @(negedge clk);
    drive(mk(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0));
    repeat (254) @(posedge clk);
    #1;
    chk("sat reach 255", 32'(stall_count), 255);
    repeat (46) @(posedge clk);
    #1;
    chk("sat hold 255", 32'(stall_count), 255);
    @(negedge clk);
    drive(idle);
    @(posedge clk);
    #1;
    chk("sat after idle", 32'(stall_count), 255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
